// File: rtl/rpn_ctrl_if.sv
// Token channel into the RPN controller.
// Master offers opcode/operand tokens; slave accepts on valid && ready.
interface rpn_ctrl_if;
   logic       tok_valid;
   logic       tok_ready;
   logic [2:0] tok_op;
   logic [7:0] tok_data;

   modport master (
      output tok_valid,
      output tok_op,
      output tok_data,
      input  tok_ready
   );

   modport slave (
      input  tok_valid,
      input  tok_op,
      input  tok_data,
      output tok_ready
   );
endinterface

// File: rtl/rpn_ctrl.sv
// RPN evaluator controller: sequences push/pop strobes on an external
// 16x8 stack, runs an 8-bit ALU and emits popped results.
module rpn_ctrl (
   input  logic       clk,
   input  logic       rst_n,
   rpn_ctrl_if.slave  tok,
   output logic       stk_we,
   output logic       stk_re,
   output logic [7:0] stk_din,
   input  logic [7:0] stk_dout,
   input  logic       stk_full,
   input  logic       stk_empty,
   output logic       res_valid,
   output logic [7:0] res_data,
   output logic [4:0] depth,
   output logic       err_ovf,
   output logic       err_unf,
   output logic       err_op,
   output logic       busy
);

   localparam logic [2:0] OP_PUSH = 3'b000;
   localparam logic [2:0] OP_ADD  = 3'b001;
   localparam logic [2:0] OP_SUB  = 3'b010;
   localparam logic [2:0] OP_AND  = 3'b011;
   localparam logic [2:0] OP_OR   = 3'b100;
   localparam logic [2:0] OP_XOR  = 3'b101;
   localparam logic [2:0] OP_OUT  = 3'b110;
   localparam logic [2:0] OP_RSV  = 3'b111;

   typedef enum logic [2:0] {
      IDLE,
      PUSH,
      POP_B,
      POP_A,
      CALC,
      EMIT
   } state_t;

   state_t     state;
   logic [2:0] op_q;
   logic [7:0] b_q;

   logic is_push;
   logic is_bin;
   logic is_out;
   logic is_rsv;

   assign is_push = (tok.tok_op == OP_PUSH);
   assign is_out  = (tok.tok_op == OP_OUT);
   assign is_rsv  = (tok.tok_op == OP_RSV);
   assign is_bin  = !is_push && !is_out && !is_rsv;

   // A is the deeper operand, so SUB yields A - B.
   function automatic logic [7:0] alu(
      input logic [2:0] op,
      input logic [7:0] a,
      input logic [7:0] b
   );
      case (op)
         OP_ADD:  alu = a + b;
         OP_SUB:  alu = a - b;
         OP_AND:  alu = a & b;
         OP_OR:   alu = a | b;
         default: alu = a ^ b;
      endcase
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         op_q          <= OP_PUSH;
         b_q           <= '0;
         depth         <= '0;
         stk_we        <= 1'b0;
         stk_re        <= 1'b0;
         stk_din       <= '0;
         res_valid     <= 1'b0;
         res_data      <= '0;
         err_ovf       <= 1'b0;
         err_unf       <= 1'b0;
         err_op        <= 1'b0;
         busy          <= 1'b0;
         tok.tok_ready <= 1'b0;
      end else begin
         stk_we    <= 1'b0;
         stk_re    <= 1'b0;
         res_valid <= 1'b0;
         unique case (state)
            IDLE: begin
               tok.tok_ready <= 1'b1;
               if (tok.tok_valid && tok.tok_ready) begin
                  unique case (1'b1)
                     is_push: begin
                        if (depth < 5'd16 && !stk_full) begin
                           stk_din       <= tok.tok_data;
                           stk_we        <= 1'b1;
                           state         <= PUSH;
                           busy          <= 1'b1;
                           tok.tok_ready <= 1'b0;
                        end else begin
                           err_ovf <= 1'b1;
                        end
                     end
                     is_bin: begin
                        if (depth >= 5'd2 && !stk_empty) begin
                           op_q          <= tok.tok_op;
                           stk_re        <= 1'b1;
                           state         <= POP_B;
                           busy          <= 1'b1;
                           tok.tok_ready <= 1'b0;
                        end else begin
                           err_unf <= 1'b1;
                        end
                     end
                     is_out: begin
                        if (depth >= 5'd1 && !stk_empty) begin
                           op_q          <= tok.tok_op;
                           stk_re        <= 1'b1;
                           state         <= POP_B;
                           busy          <= 1'b1;
                           tok.tok_ready <= 1'b0;
                        end else begin
                           err_unf <= 1'b1;
                        end
                     end
                     is_rsv: begin
                        err_op <= 1'b1;
                     end
                  endcase
               end
            end
            PUSH: begin
               depth         <= depth + 5'd1;
               state         <= IDLE;
               busy          <= 1'b0;
               tok.tok_ready <= 1'b1;
            end
            POP_B: begin
               depth <= depth - 5'd1;
               if (op_q == OP_OUT) begin
                  state <= EMIT;
               end else begin
                  stk_re <= 1'b1;
                  state  <= POP_A;
               end
            end
            POP_A: begin
               depth <= depth - 5'd1;
               b_q   <= stk_dout;
               state <= CALC;
            end
            CALC: begin
               stk_din <= alu(op_q, stk_dout, b_q);
               stk_we  <= 1'b1;
               state   <= PUSH;
            end
            EMIT: begin
               res_data      <= stk_dout;
               res_valid     <= 1'b1;
               state         <= IDLE;
               busy          <= 1'b0;
               tok.tok_ready <= 1'b1;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rpn_ctrl.sv
// Bench for rpn_ctrl: behavioural stack plus a queue-based RPN model
// predicting pushes, results, depth, flags and token latency.
module tb_rpn_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       stk_we;
   logic       stk_re;
   logic [7:0] stk_din;
   logic [7:0] stk_dout;
   logic       stk_full;
   logic       stk_empty;
   logic       res_valid;
   logic [7:0] res_data;
   logic [4:0] depth;
   logic       err_ovf;
   logic       err_unf;
   logic       err_op;
   logic       busy;

   rpn_ctrl_if tif ();

   rpn_ctrl dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .tok       (tif),
      .stk_we    (stk_we),
      .stk_re    (stk_re),
      .stk_din   (stk_din),
      .stk_dout  (stk_dout),
      .stk_full  (stk_full),
      .stk_empty (stk_empty),
      .res_valid (res_valid),
      .res_data  (res_data),
      .depth     (depth),
      .err_ovf   (err_ovf),
      .err_unf   (err_unf),
      .err_op    (err_op),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // external stack
   logic [7:0] mem [16];
   int         sp;

   assign stk_full  = (sp == 16);
   assign stk_empty = (sp == 0);

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sp       <= 0;
         stk_dout <= '0;
      end else if (stk_we && sp < 16) begin
         mem[sp] <= stk_din;
         sp      <= sp + 1;
      end else if (stk_re && sp > 0) begin
         stk_dout <= mem[sp-1];
         sp       <= sp - 1;
      end
   end

   // bus monitor
   int         we_q[$];
   int         res_q[$];
   int         re_cnt;
   int         both_cnt;

   always @(negedge clk) begin
      if (stk_we) we_q.push_back(int'(stk_din));
      if (stk_re) re_cnt <= re_cnt + 1;
      if (stk_we && stk_re) both_cnt <= both_cnt + 1;
      if (res_valid) res_q.push_back(int'(res_data));
   end

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // reference model
   int ref_stk[$];
   int m_ovf, m_unf, m_op;
   int last_res;

   function automatic int calc(input int op, input int a, input int b);
      case (op)
         1: return (a + b) & 255;
         2: return (a - b + 256) & 255;
         3: return a & b;
         4: return a | b;
         default: return a ^ b;
      endcase
   endfunction

   task automatic issue(input int op, input int data);
      int n;
      @(negedge clk);
      we_q.delete();
      res_q.delete();
      re_cnt         = 0;
      tif.tok_op     = 3'(op);
      tif.tok_data   = 8'(data);
      tif.tok_valid  = 1'b1;
      n = 0;
      while (!tif.tok_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) chk("ready_timeout", 0, 1);
      @(posedge clk);
      #1 tif.tok_valid = 1'b0;
   endtask

   task automatic step(input int op, input int data);
      int exp_we[$];
      int exp_res[$];
      int exp_re;
      int exp_lat;
      int k;
      int a, b;
      exp_re  = 0;
      exp_lat = 1;
      if (op == 0) begin
         if (ref_stk.size() < 16) begin
            ref_stk.push_back(data & 255);
            exp_we.push_back(data & 255);
            exp_lat = 2;
         end else m_ovf = 1;
      end else if (op >= 1 && op <= 5) begin
         if (ref_stk.size() >= 2) begin
            b = ref_stk.pop_back();
            a = ref_stk.pop_back();
            ref_stk.push_back(calc(op, a, b));
            exp_we.push_back(calc(op, a, b));
            exp_re  = 2;
            exp_lat = 5;
         end else m_unf = 1;
      end else if (op == 6) begin
         if (ref_stk.size() >= 1) begin
            last_res = ref_stk.pop_back();
            exp_res.push_back(last_res);
            exp_re  = 1;
            exp_lat = 3;
         end else m_unf = 1;
      end else m_op = 1;

      issue(op, data);
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!tif.tok_ready && k < 50);
      chk("latency", k, exp_lat);
      @(negedge clk);

      chk("we_count", we_q.size(), exp_we.size());
      if (we_q.size() == exp_we.size())
         foreach (exp_we[i]) chk("we_data", we_q[i], exp_we[i]);
      chk("re_count", re_cnt, exp_re);
      chk("res_count", res_q.size(), exp_res.size());
      if (res_q.size() == 1 && exp_res.size() == 1)
         chk("res_pulse", res_q[0], exp_res[0]);
      chk("res_hold", int'(res_data), last_res);
      chk("depth", int'(depth), ref_stk.size());
      chk("err_ovf", int'(err_ovf), m_ovf);
      chk("err_unf", int'(err_unf), m_unf);
      chk("err_op", int'(err_op), m_op);
      chk("busy_idle", int'(busy), 0);
      chk("we_re_overlap", both_cnt, 0);
   endtask

   task automatic model_reset();
      ref_stk.delete();
      m_ovf    = 0;
      m_unf    = 0;
      m_op     = 0;
      last_res = 0;
   endtask

   initial begin
      int op;
      tif.tok_valid = 1'b0;
      tif.tok_op    = '0;
      tif.tok_data  = '0;
      re_cnt        = 0;
      both_cnt      = 0;
      model_reset();
      rst_n = 1'b0;
      #1;
      chk("rst_ready", int'(tif.tok_ready), 0);
      chk("rst_depth", int'(depth), 0);
      chk("rst_flags", int'({err_ovf, err_unf, err_op}), 0);
      chk("rst_strobes", int'({stk_we, stk_re, res_valid, busy}), 0);
      chk("rst_data", int'({stk_din, res_data}), 0);
      repeat (3) @(negedge clk);
      chk("rst_ready_hold", int'(tif.tok_ready), 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1 chk("ready_after_rst", int'(tif.tok_ready), 1);

      // 5 3 + OUT
      step(0, 8'h05);
      step(0, 8'h03);
      step(1, 0);
      step(6, 0);
      chk("add_out", int'(res_data), 8'h08);
      // 2 5 - -> FD
      step(0, 8'h02);
      step(0, 8'h05);
      step(2, 0);
      step(6, 0);
      chk("sub_wrap", int'(res_data), 8'hFD);
      // underflow with one entry, then empty OUT
      step(0, 8'h11);
      step(1, 0);
      step(6, 0);
      step(6, 0);
      // reserved opcode then normal push
      step(7, 0);
      step(0, 8'h44);
      step(6, 0);
      // fill to 16 then overflow
      for (int i = 0; i < 17; i++) step(0, i + 8'h20);
      chk("full_depth", int'(depth), 16);
      for (int i = 0; i < 8; i++) step(1 + (i % 5), 0);

      // reset while in POP_A of an ADD
      rst_n = 1'b0;
      #1 rst_n = 1'b1;
      model_reset();
      step(0, 8'h0A);
      step(0, 8'h0B);
      issue(1, 0);
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      model_reset();
      chk("mid_rst_depth", int'(depth), 0);
      chk("mid_rst_busy", int'(busy), 0);
      chk("mid_rst_strobes", int'({stk_we, stk_re, res_valid}), 0);
      chk("mid_rst_flags", int'({err_ovf, err_unf, err_op}), 0);
      @(negedge clk);
      we_q.delete();
      re_cnt = 0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      chk("post_rst_we", we_q.size(), 0);
      chk("post_rst_re", re_cnt, 0);
      step(0, 8'h44);

      // random traffic
      for (int i = 0; i < 300; i++) begin
         op = $urandom_range(0, 9);
         if (op > 7) op = 0;
         step(op, $urandom_range(0, 255));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got=running exp=done");
      $fatal(1);
   end

endmodule
